// File: rtl/dct_stage1_xpose_ctrl.sv
// dct_stage1_xpose_ctrl: fills the 8x8 stage-1 array column by column, then streams it back row by row (transpose).
// Ports: clk; rst (async, active high); flush (sync abort of the current block);
//  in_valid/in_ready column handshake; wr_en_entry[c][e] write enables to the array;
//  arr_data[c][e] array contents (signed, SIZE bits); out_valid/out_ready row handshake;
//  out_data[c] = arr_data[c][row_cnt]; out_sob marks row 0, out_eob marks row 7.
// Optional: `define DCT_XPOSE_BLKCNT_EN adds blk_cnt[15:0], count of fully drained blocks (wraps).
module dct_stage1_xpose_ctrl #(
  parameter int SIZE = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [7:0][7:0]                   wr_en_entry,
  input  logic signed [7:0][7:0][SIZE-1:0]  arr_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [7:0][SIZE-1:0]       out_data,
`ifdef DCT_XPOSE_BLKCNT_EN
  output logic [15:0]                       blk_cnt,
`endif
  output logic                              out_sob,
  output logic                              out_eob
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nxt;
  logic [2:0] col_cnt, row_cnt, col_nxt, row_nxt;
  logic in_hs, out_hs;
  // flush suppresses both handshakes so nothing is written or counted in the abort cycle
  assign in_hs  = state == FILL && in_valid && !flush;
  assign out_hs = state == DRAIN && out_ready && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= FILL;
      col_cnt <= 3'd0;
      row_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  always_comb begin
    state_nxt = flush ? FILL :
                (in_hs && col_cnt == 3'd7) ? DRAIN :
                (out_hs && row_cnt == 3'd7) ? FILL : state;
    col_nxt   = flush ? 3'd0 : in_hs ? col_cnt + 3'd1 : col_cnt;
    row_nxt   = flush ? 3'd0 : out_hs ? row_cnt + 3'd1 : row_cnt;
  end
  // wr_en is gated by rst so an asserted reset never writes the array
  always_comb begin
    in_ready    = state == FILL;
    out_valid   = state == DRAIN;
    out_sob     = out_valid && row_cnt == 3'd0;
    out_eob     = out_valid && row_cnt == 3'd7;
    wr_en_entry = '0;
    if (in_hs && !rst) wr_en_entry[col_cnt] = 8'hFF;
  end
  for (genvar c = 0; c < 8; c++) begin : g_row
    assign out_data[c] = arr_data[c][row_cnt];
  end
`ifdef DCT_XPOSE_BLKCNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) blk_cnt <= 16'd0;
    else if (out_hs && row_cnt == 3'd7) blk_cnt <= blk_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_dct_stage1_xpose_ctrl.sv
// tb_dct_stage1_xpose_ctrl: scoreboard bench for the transpose controller with a behavioural 8x8 array.
module tb_dct_stage1_xpose_ctrl;
  localparam int SIZE = 10;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_sob, out_eob;
  logic [7:0][7:0] wr_en_entry;
  logic signed [7:0][7:0][SIZE-1:0] arr_data;
  logic signed [7:0][SIZE-1:0] out_data, col_in;
`ifdef DCT_XPOSE_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif
  typedef struct {
    logic [7:0][SIZE-1:0] d;
    logic sob;
    logic eob;
  } row_t;
  row_t sb[$];
  logic signed [SIZE-1:0] blk [8][8];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  dct_stage1_xpose_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en_entry(wr_en_entry), .arr_data(arr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef DCT_XPOSE_BLKCNT_EN
    .blk_cnt(blk_cnt),
`endif
    .out_sob(out_sob), .out_eob(out_eob)
  );
  always @(posedge clk)
    for (int c = 0; c < 8; c++)
      for (int e = 0; e < 8; e++)
        if (wr_en_entry[c][e]) arr_data[c][e] <= col_in[e];
  task automatic send_block(input int mode, input int ncols);
    row_t ex;
    logic [63:0] we;
    for (int c = 0; c < 8; c++)
      for (int e = 0; e < 8; e++)
        blk[c][e] = mode == 0 ? SIZE'(c * 8 + e) :
                    mode == 1 ? (((c + e) % 2) == 1 ? SIZE'(511) : SIZE'(-512)) : SIZE'($urandom);
    for (int c = 0; c < ncols; c++) begin
      in_valid = 1;
      for (int e = 0; e < 8; e++) col_in[e] = blk[c][e];
      #1;
      we = 64'hFF << (8 * c);
      tests++;
      if (wr_en_entry !== we) begin
        fails++;
        $display("FAIL fill_wr_en col %0d: got %h want %h", c, wr_en_entry, we);
      end
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL fill_flags col %0d: in_ready %b out_valid %b want 1 0", c, in_ready, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 0;
    if (ncols == 8) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) ex.d[c] = blk[c][r];
        ex.sob = r == 0;
        ex.eob = r == 7;
        sb.push_back(ex);
      end
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_sob !== 1'b1) begin
        fails++;
        $display("FAIL latency: out_valid %b out_sob %b want 1 1", out_valid, out_sob);
      end
    end
  endtask
  task automatic drain(input int stall_row, input int stall_len, input int stop_at, input bit in_busy);
    int n = 0, cyc = 0, st = 0;
    row_t ex;
    in_valid = in_busy;
    while (n < stop_at && cyc < 100) begin
      out_ready = !(n == stall_row && st < stall_len);
      #1;
      if (out_valid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (in_ready !== 1'b0 || wr_en_entry !== '0) begin
          fails++;
          $display("FAIL drain_quiet row %0d: in_ready %b wr_en %h want 0 0", n, in_ready, wr_en_entry);
        end
        ex = sb[0];
        tests++;
        if (out_data !== ex.d || out_sob !== ex.sob || out_eob !== ex.eob) begin
          fails++;
          $display("FAIL row %0d: got %h sob %b eob %b want %h sob %b eob %b",
                   n, out_data, out_sob, out_eob, ex.d, ex.sob, ex.eob);
        end
        if (out_ready) begin
          sb.delete(0);
          n++;
        end else st++;
      end
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (n != stop_at || cyc != stop_at + st) begin
      fails++;
      $display("FAIL drain_timing: rows %0d in %0d cycles want %0d in %0d", n, cyc, stop_at, stop_at + st);
    end
    in_valid = 0;
    out_ready = 1;
  endtask
  task automatic check_idle(input string name);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sob !== 1'b0 || out_eob !== 1'b0 || wr_en_entry !== '0) begin
      fails++;
      $display("FAIL %s: in_ready %b out_valid %b sob %b eob %b wr_en %h want 1 0 0 0 0",
               name, in_ready, out_valid, out_sob, out_eob, wr_en_entry);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    in_valid = 1;
    @(negedge clk);
    #1;
    check_idle("reset");
`ifdef DCT_XPOSE_BLKCNT_EN
    tests++;
    if (blk_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt);
    end
`endif
    rst = 0;
    in_valid = 0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    send_block(0, 8);
    drain(-1, 0, 8, 0);
  endtask
  task automatic test_signed();
    send_block(1, 8);
    drain(-1, 0, 8, 1);
  endtask
  task automatic test_stall();
    send_block(2, 8);
    drain(3, 5, 8, 0);
  endtask
  task automatic test_back_to_back();
    send_block(2, 8);
    drain(-1, 0, 8, 0);
    send_block(2, 8);
    drain(-1, 0, 8, 0);
  endtask
  task automatic test_flush();
    send_block(2, 4);
    in_valid = 1;
    col_in = '1;
    flush = 1;
    #1;
    tests++;
    if (wr_en_entry !== '0) begin
      fails++;
      $display("FAIL flush_no_write: got %h want 0", wr_en_entry);
    end
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    #1;
    check_idle("flush_fill");
    @(negedge clk);
    send_block(2, 8);
    drain(-1, 0, 8, 0);
    send_block(2, 8);
    drain(-1, 0, 2, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    check_idle("flush_drain");
    sb.delete();
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    send_block(2, 8);
    drain(-1, 0, 5, 0);
    #2;
    rst = 1;
    in_valid = 1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    #1;
    check_idle("after_reset");
    sb.delete();
    @(negedge clk);
    send_block(0, 8);
    drain(-1, 0, 8, 0);
  endtask
`ifdef DCT_XPOSE_BLKCNT_EN
  task automatic test_blkcnt();
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      send_block(2, 8);
      drain(-1, 0, 8, 0);
    end
    send_block(2, 8);
    drain(-1, 0, 7, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    sb.delete();
    #1;
    tests++;
    if (blk_cnt !== 16'd3) begin
      fails++;
      $display("FAIL blk_cnt: got %0d want 3", blk_cnt);
    end
    @(negedge clk);
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef DCT_XPOSE_BLKCNT_EN
    test_blkcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
